vector_accum: RTL and testbench

Parametrised multi-channel vector accumulator. It is the successor to the fixed two-lane, 8-bit vector sum block. It accepts a stream of CHANNELS-wide input vectors under a valid/ready handshake and accumulates each lane over a frame of FRAME_LEN accepted beats. At the end of each frame it emits per-lane sums, a cross-lane total and an overflow flag. It sits between a vector source and a downstream consumer that applies backpressure.

---
 rtl/vector_accum_pkg.sv | 24 ++
 rtl/vector_accum_lane.sv | 79 +++++++
 rtl/vector_accum.sv | 165 ++++++++++++++++
 tb/tb_vector_accum.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_accum_pkg.sv
// -----------------------------------------------------------------------------
// vector_accum_pkg
// Shared types and width helpers for the vector_accum block.
//   state_e      : frame FSM state (ACCUM collects beats, EMIT holds a result)
//   total_width  : width of the cross-lane total, sized so the sum of all lanes
//                  at their maximum value can never overflow
//   count_width  : width of the beat counter, able to hold 0..frame_len
// -----------------------------------------------------------------------------
package vector_accum_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_e;

  function automatic int total_width(input int acc_width, input int channels);
    return acc_width + $clog2(channels) + 1;
  endfunction

  function automatic int count_width(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/vector_accum_lane.sv
// -----------------------------------------------------------------------------
// vector_accum_lane
// One lane of the vector accumulator: accumulator register, adder, carry-out
// detect, sticky per-frame overflow flag and wrap/saturate handling.
// Build option: VECTOR_ACCUM_SATURATE_EN defined -> an overflowing add clamps
// the lane to all-ones (and it stays there, since any further non-zero add
// overflows again); undefined -> the lane wraps modulo 2^ACC_WIDTH.
// Ports:
//   clk, reset_l : clock, asynchronous active-low reset
//   load_zero    : zero accumulator and flag at the next edge (wins over enable)
//   enable       : add in_data to the accumulator at the next edge
//   in_data      : unsigned lane input
//   value        : accumulator as it stands after this cycle's update
//   overflow     : frame overflow flag as it stands after this cycle's update
// -----------------------------------------------------------------------------
module vector_accum_lane #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic                 load_zero,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     in_data,
  output logic [ACC_WIDTH-1:0] value,
  output logic                 overflow
);

  logic [ACC_WIDTH-1:0] acc_r;
  logic [ACC_WIDTH-1:0] acc_nxt_s;
  logic                 ovf_r;
  logic                 ovf_nxt_s;
  logic [ACC_WIDTH:0]   sum_s;
  logic                 carry_s;

  // One extra bit on the adder captures the carry out of the accumulator.
  assign sum_s   = {1'b0, acc_r} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, in_data};
  assign carry_s = sum_s[ACC_WIDTH];

  // Next accumulator value and sticky overflow flag.
  always_comb begin
    acc_nxt_s = acc_r;
    ovf_nxt_s = ovf_r;
    if (load_zero) begin
      acc_nxt_s = '0;
      ovf_nxt_s = 1'b0;
    end else if (enable) begin
      if (carry_s) begin
`ifdef VECTOR_ACCUM_SATURATE_EN
        acc_nxt_s = '1;
`else
        acc_nxt_s = sum_s[ACC_WIDTH-1:0];
`endif
        ovf_nxt_s = 1'b1;
      end else begin
        acc_nxt_s = sum_s[ACC_WIDTH-1:0];
        ovf_nxt_s = ovf_r;
      end
    end else begin
      acc_nxt_s = acc_r;
      ovf_nxt_s = ovf_r;
    end
  end

  // Accumulator and flag registers.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      acc_r <= '0;
      ovf_r <= 1'b0;
    end else begin
      acc_r <= acc_nxt_s;
      ovf_r <= ovf_nxt_s;
    end
  end

  assign value    = acc_nxt_s;
  assign overflow = ovf_nxt_s;

endmodule

// File: rtl/vector_accum.sv
// -----------------------------------------------------------------------------
// vector_accum
// Multi-channel vector accumulator. Accepts CHANNELS-lane beats under
// valid/ready, sums each lane over FRAME_LEN accepted beats, then presents the
// per-lane sums, a full-width cross-lane total and an overflow flag until the
// consumer takes them. No new beat is accepted while a result is pending.
// Build option: VECTOR_ACCUM_SATURATE_EN (see vector_accum_lane) selects lane
// saturation instead of wrap on overflow.
// Ports:
//   clk, reset_l  : clock, asynchronous active-low reset
//   clear         : synchronous frame abort, beats with clear are dropped
//   in_valid/in_ready/in_data   : input beat handshake, lane k at [k*WIDTH +: WIDTH]
//   out_valid/out_ready         : result handshake
//   out_sum       : lane k sum at [k*ACC_WIDTH +: ACC_WIDTH]
//   out_total     : sum of all out_sum lanes
//   out_overflow  : at least one lane overflowed during the frame
// All outputs are driven straight from registers.
// -----------------------------------------------------------------------------
module vector_accum
  import vector_accum_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 2,
  parameter int ACC_WIDTH = 16,
  parameter int FRAME_LEN = 4
) (
  input  logic                                          clk,
  input  logic                                          reset_l,
  input  logic                                          clear,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [CHANNELS*WIDTH-1:0]                     in_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [CHANNELS*ACC_WIDTH-1:0]                 out_sum,
  output logic [total_width(ACC_WIDTH, CHANNELS)-1:0]   out_total,
  output logic                                          out_overflow
);

  localparam int TOT_W = total_width(ACC_WIDTH, CHANNELS);
  localparam int CNT_W = count_width(FRAME_LEN);

  state_e                        state_r;
  state_e                        state_nxt_s;
  logic [CNT_W-1:0]              cnt_r;
  logic [CNT_W-1:0]              cnt_nxt_s;
  logic                          in_ready_r;
  logic                          out_valid_r;
  logic [CHANNELS*ACC_WIDTH-1:0] out_sum_r;
  logic [TOT_W-1:0]              out_total_r;
  logic                          out_overflow_r;

  logic                          accept_s;
  logic                          last_beat_s;
  logic                          frame_end_s;
  logic                          consume_s;
  logic                          lane_zero_s;
  logic [CHANNELS*ACC_WIDTH-1:0] lane_val_s;
  logic [CHANNELS-1:0]           lane_ovf_s;
  logic [TOT_W-1:0]              total_s;
  logic                          any_ovf_s;

  // clear masks the handshake so a beat presented with it is never counted.
  assign accept_s    = in_valid && in_ready_r && !clear;
  assign last_beat_s = (cnt_r == CNT_W'(FRAME_LEN - 1));
  assign frame_end_s = accept_s && last_beat_s;
  assign consume_s   = (state_r == EMIT) && out_ready && !clear;
  assign lane_zero_s = clear || consume_s;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    vector_accum_lane #(
      .WIDTH     (WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk       (clk),
      .reset_l   (reset_l),
      .load_zero (lane_zero_s),
      .enable    (accept_s),
      .in_data   (in_data[k*WIDTH +: WIDTH]),
      .value     (lane_val_s[k*ACC_WIDTH +: ACC_WIDTH]),
      .overflow  (lane_ovf_s[k])
    );
  end

  // Cross-lane total of the post-update lane values, at full width.
  always_comb begin
    total_s   = '0;
    any_ovf_s = |lane_ovf_s;
    for (int k = 0; k < CHANNELS; k++) begin
      total_s = total_s + TOT_W'(lane_val_s[k*ACC_WIDTH +: ACC_WIDTH]);
    end
  end

  // Frame FSM next state and beat counter.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (clear) begin
      state_nxt_s = ACCUM;
      cnt_nxt_s   = '0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (accept_s) begin
            if (last_beat_s) begin
              state_nxt_s = EMIT;
              cnt_nxt_s   = '0;
            end else begin
              state_nxt_s = ACCUM;
              cnt_nxt_s   = cnt_r + CNT_W'(1);
            end
          end else begin
            state_nxt_s = ACCUM;
            cnt_nxt_s   = cnt_r;
          end
        end
        EMIT: begin
          if (out_ready) begin
            state_nxt_s = ACCUM;
          end else begin
            state_nxt_s = EMIT;
          end
        end
        default: begin
          state_nxt_s = ACCUM;
          cnt_nxt_s   = '0;
        end
      endcase
    end
  end

  // State, handshake flags and result registers.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_r        <= ACCUM;
      cnt_r          <= '0;
      in_ready_r     <= 1'b1;
      out_valid_r    <= 1'b0;
      out_sum_r      <= '0;
      out_total_r    <= '0;
      out_overflow_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      in_ready_r  <= (state_nxt_s == ACCUM);
      out_valid_r <= (state_nxt_s == EMIT);
      if (lane_zero_s) begin
        out_sum_r      <= '0;
        out_total_r    <= '0;
        out_overflow_r <= 1'b0;
      end else if (frame_end_s) begin
        out_sum_r      <= lane_val_s;
        out_total_r    <= total_s;
        out_overflow_r <= any_ovf_s;
      end
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign out_sum      = out_sum_r;
  assign out_total    = out_total_r;
  assign out_overflow = out_overflow_r;

endmodule

// File: tb/tb_vector_accum.sv
// -----------------------------------------------------------------------------
// tb_vector_accum
// Self-checking bench for vector_accum with WIDTH=8, CHANNELS=2, ACC_WIDTH=9,
// FRAME_LEN=4. A lane-level arithmetic model (integer sums with wrap or clamp
// at 2^ACC_WIDTH) predicts every frame result.
// -----------------------------------------------------------------------------
module tb_vector_accum;

  localparam int WIDTH     = 8;
  localparam int CHANNELS  = 2;
  localparam int ACC_WIDTH = 9;
  localparam int FRAME_LEN = 4;
  localparam int TOT_W     = ACC_WIDTH + $clog2(CHANNELS) + 1;
  localparam int RES_W     = 2 + TOT_W + CHANNELS * ACC_WIDTH;
  localparam int ACC_MAX   = (1 << ACC_WIDTH) - 1;
`ifdef VECTOR_ACCUM_SATURATE_EN
  localparam int OVF_LANE1 = 511;
  localparam int OVF_TOTAL_LANE1 = 511;
`else
  localparam int OVF_LANE1 = 288;
  localparam int OVF_TOTAL_LANE1 = 288;
`endif

  logic                          clk = 1'b0;
  logic                          reset_l;
  logic                          clear;
  logic                          in_valid;
  logic                          in_ready;
  logic [CHANNELS*WIDTH-1:0]     in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [CHANNELS*ACC_WIDTH-1:0] out_sum;
  logic [TOT_W-1:0]              out_total;
  logic                          out_overflow;

  int pass_cnt  = 0;
  int check_cnt = 0;

  // Reference model state: plain integer lane sums for the current frame.
  int m_acc [CHANNELS];
  bit m_ovf;

  always #5 clk = ~clk;

  vector_accum #(
    .WIDTH     (WIDTH),
    .CHANNELS  (CHANNELS),
    .ACC_WIDTH (ACC_WIDTH),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .clk          (clk),
    .reset_l      (reset_l),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_total    (out_total),
    .out_overflow (out_overflow)
  );

  function automatic void model_clear();
    for (int k = 0; k < CHANNELS; k++) m_acc[k] = 0;
    m_ovf = 1'b0;
  endfunction

  function automatic void model_beat(input int v0, input int v1);
    int v [CHANNELS];
    v[0] = v0;
    v[1] = v1;
    for (int k = 0; k < CHANNELS; k++) begin
      m_acc[k] = m_acc[k] + v[k];
      if (m_acc[k] > ACC_MAX) begin
        m_ovf = 1'b1;
`ifdef VECTOR_ACCUM_SATURATE_EN
        m_acc[k] = ACC_MAX;
`else
        m_acc[k] = m_acc[k] - (ACC_MAX + 1);
`endif
      end
    end
  endfunction

  // Expected {out_valid, out_overflow, out_total, out_sum} for a pending result.
  function automatic logic [RES_W-1:0] model_result();
    logic [CHANNELS*ACC_WIDTH-1:0] s;
    logic [TOT_W-1:0]              t;
    s = '0;
    t = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      s[k*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(m_acc[k]);
      t = t + TOT_W'(m_acc[k]);
    end
    return {1'b1, m_ovf, t, s};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and wait for it to be taken; cycles = edges spent.
  task automatic send_beat(input int v0, input int v1, output int cycles);
    logic rdy;
    rdy      = 1'b0;
    in_valid = 1'b1;
    in_data  = {WIDTH'(v1), WIDTH'(v0)};
    cycles   = 0;
    while (cycles < 50) begin
      rdy = in_ready;
      step();
      cycles++;
      if (rdy) break;
    end
    in_valid = 1'b0;
    if (!rdy) begin
      check_cnt++;
      $display("FAIL send_beat_timeout: in_ready still %0b after %0d cycles, required 1", in_ready, cycles);
    end else begin
      model_beat(v0, v1);
    end
  endtask

  task automatic test_reset();
    reset_l   = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    model_clear();
    #12;
    check_cnt++;
    if ({out_valid, out_overflow, out_total, out_sum} !== RES_W'(0)) begin
      $display("FAIL reset_outputs: got %h, required 0", {out_valid, out_overflow, out_total, out_sum});
    end else pass_cnt++;
    check_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    else pass_cnt++;
    step();
    reset_l = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int c;
    out_ready = 1'b1;
    model_clear();
    for (int i = 0; i < FRAME_LEN; i++) send_beat(i + 1, 100, c);
    check_cnt++;
    if ({out_valid, out_overflow, out_total, out_sum} !== model_result())
      $display("FAIL basic_result: got %h, required %h", {out_valid, out_overflow, out_total, out_sum}, model_result());
    else pass_cnt++;
    check_cnt++;
    if ({out_total, out_sum} !== {11'd410, 9'd400, 9'd10})
      $display("FAIL basic_values: got total %0d sum %h, required 410 / lanes 10,400", out_total, out_sum);
    else pass_cnt++;
    check_cnt++;
    if (in_ready !== 1'b0) $display("FAIL basic_in_ready_emit: got %b, required 0", in_ready);
    else pass_cnt++;
    step();
    check_cnt++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL basic_one_cycle: got valid/ready %b%b, required 01", out_valid, in_ready);
    else pass_cnt++;
    model_clear();
  endtask

  task automatic test_overflow();
    int c;
    int l0;
    out_ready = 1'b1;
    model_clear();
    l0 = 0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      int v;
      v  = $urandom_range(0, 60);
      l0 = l0 + v;
      send_beat(v, 200, c);
    end
    check_cnt++;
    if ({out_valid, out_overflow, out_total, out_sum} !== model_result())
      $display("FAIL overflow_result: got %h, required %h", {out_valid, out_overflow, out_total, out_sum}, model_result());
    else pass_cnt++;
    check_cnt++;
    if ({out_overflow, out_sum[2*ACC_WIDTH-1:ACC_WIDTH], out_total} !== {1'b1, 9'(OVF_LANE1), 11'(OVF_TOTAL_LANE1 + l0)})
      $display("FAIL overflow_lane1: got ovf %b lane1 %0d total %0d, required 1 / %0d / %0d",
               out_overflow, out_sum[2*ACC_WIDTH-1:ACC_WIDTH], out_total, OVF_LANE1, OVF_TOTAL_LANE1 + l0);
    else pass_cnt++;
    step();
    model_clear();
  endtask

  task automatic test_backpressure();
    int c;
    out_ready = 1'b0;
    model_clear();
    for (int i = 0; i < FRAME_LEN; i++) send_beat($urandom_range(0, 255), $urandom_range(0, 255), c);
    for (int i = 0; i < 5; i++) begin
      check_cnt++;
      if ({out_valid, out_overflow, out_total, out_sum} !== model_result())
        $display("FAIL bp_hold_%0d: got %h, required %h", i, {out_valid, out_overflow, out_total, out_sum}, model_result());
      else pass_cnt++;
      check_cnt++;
      if (in_ready !== 1'b0) $display("FAIL bp_in_ready_%0d: got %b, required 0", i, in_ready);
      else pass_cnt++;
      step();
    end
    // Offer the next beat in the same cycle the result is released.
    in_valid  = 1'b1;
    in_data   = {WIDTH'(7), WIDTH'(3)};
    out_ready = 1'b1;
    step();
    model_clear();
    check_cnt++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL bp_release: got valid/ready %b%b, required 01", out_valid, in_ready);
    else pass_cnt++;
    send_beat(3, 7, c);
    check_cnt++;
    if (c !== 1) $display("FAIL bp_first_accept: took %0d cycles, required 1", c);
    else pass_cnt++;
    for (int i = 1; i < FRAME_LEN; i++) send_beat($urandom_range(0, 255), $urandom_range(0, 255), c);
    check_cnt++;
    if ({out_valid, out_overflow, out_total, out_sum} !== model_result())
      $display("FAIL bp_next_frame: got %h, required %h", {out_valid, out_overflow, out_total, out_sum}, model_result());
    else pass_cnt++;
    step();
    model_clear();
  endtask

  task automatic test_gaps();
    out_ready = 1'b1;
    model_clear();
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      int v1;
      v1       = $urandom_range(0, 255);
      in_valid = (i % 2 == 0);
      in_data  = {WIDTH'(v1), WIDTH'(1)};
      step();
      if (i % 2 == 0) model_beat(1, v1);
      if (i == 5) begin
        check_cnt++;
        if (out_valid !== 1'b0) $display("FAIL gaps_early_valid: got %b, required 0", out_valid);
        else pass_cnt++;
      end
      if (i == 6) begin
        check_cnt++;
        if ({out_valid, out_overflow, out_total, out_sum} !== model_result())
          $display("FAIL gaps_result: got %h, required %h", {out_valid, out_overflow, out_total, out_sum}, model_result());
        else pass_cnt++;
        check_cnt++;
        if (out_sum[ACC_WIDTH-1:0] !== 9'd4) $display("FAIL gaps_lane0: got %0d, required 4", out_sum[ACC_WIDTH-1:0]);
        else pass_cnt++;
      end
    end
    in_valid = 1'b0;
    check_cnt++;
    if (out_valid !== 1'b0) $display("FAIL gaps_consumed: got %b, required 0", out_valid);
    else pass_cnt++;
    model_clear();
  endtask

  task automatic test_clear();
    int c;
    out_ready = 1'b1;
    model_clear();
    send_beat(5, 9, c);
    send_beat(5, 9, c);
    in_valid = 1'b1;
    in_data  = {WIDTH'(9), WIDTH'(5)};
    clear    = 1'b1;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    model_clear();
    check_cnt++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL clear_accum: got valid/ready %b%b, required 01", out_valid, in_ready);
    else pass_cnt++;
    for (int i = 0; i < FRAME_LEN; i++) send_beat(5, $urandom_range(0, 255), c);
    check_cnt++;
    if ({out_valid, out_overflow, out_total, out_sum} !== model_result())
      $display("FAIL clear_next_frame: got %h, required %h", {out_valid, out_overflow, out_total, out_sum}, model_result());
    else pass_cnt++;
    check_cnt++;
    if (out_sum[ACC_WIDTH-1:0] !== 9'd20) $display("FAIL clear_lane0: got %0d, required 20", out_sum[ACC_WIDTH-1:0]);
    else pass_cnt++;
    step();
    // Clear while a result waits on a stalled consumer.
    out_ready = 1'b0;
    model_clear();
    for (int i = 0; i < FRAME_LEN; i++) send_beat($urandom_range(0, 255), $urandom_range(0, 255), c);
    check_cnt++;
    if (out_valid !== 1'b1) $display("FAIL clear_emit_before: got %b, required 1", out_valid);
    else pass_cnt++;
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_clear();
    check_cnt++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL clear_emit_drop: got valid/ready %b%b, required 01", out_valid, in_ready);
    else pass_cnt++;
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    int c;
    out_ready = 1'b1;
    model_clear();
    send_beat($urandom_range(0, 255), $urandom_range(0, 255), c);
    send_beat($urandom_range(0, 255), $urandom_range(0, 255), c);
    #2;
    reset_l = 1'b0;
    #1;
    check_cnt++;
    if ({out_valid, out_overflow, out_total, out_sum, in_ready} !== {RES_W'(0), 1'b1})
      $display("FAIL reset_mid_outputs: got %h ready %b, required 0 ready 1",
               {out_valid, out_overflow, out_total, out_sum}, in_ready);
    else pass_cnt++;
    step();
    reset_l = 1'b1;
    model_clear();
    for (int i = 0; i < FRAME_LEN; i++) send_beat(1, 1, c);
    check_cnt++;
    if ({out_valid, out_total, out_sum} !== {1'b1, 11'd8, 9'd4, 9'd4})
      $display("FAIL reset_mid_frame: got valid %b total %0d sum %h, required 1 / 8 / lanes 4,4",
               out_valid, out_total, out_sum);
    else pass_cnt++;
    step();
    model_clear();
  endtask

  task automatic test_random();
    int c;
    for (int f = 0; f < 8; f++) begin
      model_clear();
      out_ready = 1'b0;
      for (int i = 0; i < FRAME_LEN; i++) begin
        int idle;
        idle = $urandom_range(0, 2);
        for (int j = 0; j < idle; j++) step();
        send_beat($urandom_range(0, 255), $urandom_range(0, 255), c);
      end
      for (int j = 0; j <= int'($urandom_range(0, 3)); j++) begin
        check_cnt++;
        if ({out_valid, out_overflow, out_total, out_sum} !== model_result())
          $display("FAIL random_f%0d_c%0d: got %h, required %h", f, j,
                   {out_valid, out_overflow, out_total, out_sum}, model_result());
        else pass_cnt++;
        step();
      end
      out_ready = 1'b1;
      step();
      check_cnt++;
      if ({out_valid, in_ready} !== 2'b01)
        $display("FAIL random_f%0d_consume: got valid/ready %b%b, required 01", f, out_valid, in_ready);
      else pass_cnt++;
    end
    model_clear();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_gaps();
    test_clear();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
